// File: rtl/avr_cpu_pkg.sv
// Shared CPU definitions: stack controller state encoding and default stack geometry.
package avr_cpu_pkg;
  localparam int STK_WIDTH = 9;
  localparam int STK_DEPTH = 3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PUSH = 3'd1,
    ST_POP  = 3'd2,
    ST_LOAD = 3'd3,
    ST_ERR  = 3'd4
  } stk_state_e;
endpackage

// File: rtl/avr_cpu_stack.sv
// Hardware return-address stack on a shared tri-state bus; write and read take effect at the
// clock edge ending the strobe cycle, and top-of-stack is driven combinationally while stk_read=1.
module avr_cpu_stack
  import avr_cpu_pkg::*;
#(
  parameter int WIDTH = STK_WIDTH,
  parameter int DEPTH = STK_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stk_read,
  input  logic             stk_write,
  inout  wire  [WIDTH-1:0] stk_data
);
  localparam int DW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0]    sp_q, sp_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [DW-1:0]    top;

  assign top = sp_q - 1'b1;

  always_comb begin
    sp_d  = sp_q;
    mem_d = mem_q;
    if (stk_write && (sp_q != DW'(DEPTH))) begin
      mem_d[AW'(sp_q)] = stk_data;
      sp_d = sp_q + 1'b1;
    end else if (stk_read && (sp_q != '0)) begin
      sp_d = sp_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      sp_q  <= sp_d;
      mem_q <= mem_d;
    end
  end

  assign stk_data = (stk_read && (sp_q != '0)) ? mem_q[AW'(top)] : {WIDTH{1'bz}};
endmodule

// File: rtl/avr_cpu_stack_ctrl.sv
// CALL/RET/IRQ sequencer for the hardware stack: request in IDLE -> pc_load two cycles later.
// Requests are ignored while busy; overflow/underflow sets sticky err and loads no PC.
module avr_cpu_stack_ctrl
  import avr_cpu_pkg::*;
#(
  parameter int WIDTH = STK_WIDTH,
  parameter int DEPTH = STK_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         call_req,
  input  logic                         ret_req,
  input  logic                         irq_req,
  input  logic [WIDTH-1:0]             pc_ret,
  input  logic [WIDTH-1:0]             pc_target,
  input  logic [WIDTH-1:0]             irq_vec,
  output logic [WIDTH-1:0]             pc_out,
  output logic                         pc_load,
  output logic                         busy,
  output logic                         stk_read,
  output logic                         stk_write,
  inout  wire  [WIDTH-1:0]             stk_data,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic                         full,
  output logic                         empty,
  output logic                         err
);
  localparam int DW = $clog2(DEPTH + 1);

  stk_state_e       state_q, state_d;
  logic [WIDTH-1:0] ret_q, ret_d;
  logic [WIDTH-1:0] dest_q, dest_d;
  logic [WIDTH-1:0] pc_out_q, pc_out_d;
  logic [DW-1:0]    depth_q, depth_d;
  logic             err_q, err_d;
  logic             pc_load_q, pc_load_d;
  logic             busy_q, busy_d;
  logic             stk_read_q, stk_read_d;
  logic             stk_write_q, stk_write_d;
  logic             push_req, pop_req;

  // Priority irq > ret > call; losers are simply dropped.
  assign push_req = irq_req || (call_req && !ret_req);
  assign pop_req  = !irq_req && ret_req;

  assign full  = (depth_q == DW'(DEPTH));
  assign empty = (depth_q == '0);

  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    dest_d      = dest_q;
    pc_out_d    = pc_out_q;
    depth_d     = depth_q;
    err_d       = err_q;
    pc_load_d   = 1'b0;
    stk_read_d  = 1'b0;
    stk_write_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (push_req) begin
          if (full) begin
            err_d   = 1'b1;
            state_d = ST_ERR;
          end else begin
            ret_d       = pc_ret;
            dest_d      = irq_req ? irq_vec : pc_target;
            stk_write_d = 1'b1;
            state_d     = ST_PUSH;
          end
        end else if (pop_req) begin
          if (empty) begin
            err_d   = 1'b1;
            state_d = ST_ERR;
          end else begin
            stk_read_d = 1'b1;
            state_d    = ST_POP;
          end
        end
      end
      ST_PUSH: begin
        depth_d   = depth_q + 1'b1;
        pc_out_d  = dest_q;
        pc_load_d = 1'b1;
        state_d   = ST_LOAD;
      end
      ST_POP: begin
        // The stack is driving the popped address onto the bus during this cycle.
        depth_d   = depth_q - 1'b1;
        dest_d    = stk_data;
        pc_out_d  = stk_data;
        pc_load_d = 1'b1;
        state_d   = ST_LOAD;
      end
      ST_LOAD: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ret_q       <= '0;
      dest_q      <= '0;
      pc_out_q    <= '0;
      depth_q     <= '0;
      err_q       <= 1'b0;
      pc_load_q   <= 1'b0;
      busy_q      <= 1'b0;
      stk_read_q  <= 1'b0;
      stk_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      dest_q      <= dest_d;
      pc_out_q    <= pc_out_d;
      depth_q     <= depth_d;
      err_q       <= err_d;
      pc_load_q   <= pc_load_d;
      busy_q      <= busy_d;
      stk_read_q  <= stk_read_d;
      stk_write_q <= stk_write_d;
    end
  end

  assign pc_out    = pc_out_q;
  assign pc_load   = pc_load_q;
  assign busy      = busy_q;
  assign stk_read  = stk_read_q;
  assign stk_write = stk_write_q;
  assign depth     = depth_q;
  assign err       = err_q;
  assign stk_data  = stk_write_q ? ret_q : {WIDTH{1'bz}};
endmodule

// File: tb/tb_avr_cpu_stack_ctrl.sv
// Stack controller plus hardware stack on a shared bus, checked against a queue-based return-address model.
module tb_avr_cpu_stack_ctrl;
  import avr_cpu_pkg::*;

  localparam int W = 9;
  localparam int D = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         call_req, ret_req, irq_req;
  logic [W-1:0] pc_ret, pc_target, irq_vec;
  logic [W-1:0] pc_out;
  logic         pc_load, busy, stk_read, stk_write;
  wire  [W-1:0] stk_data;
  logic [1:0]   depth;
  logic         full, empty, err;

  int n_checks = 0;
  int n_errs   = 0;

  // Reference model: the stack is a queue of return addresses.
  logic [W-1:0] m_q[$];
  logic         m_err;
  logic [W-1:0] m_pc;

  always #5 clk = ~clk;

  avr_cpu_stack_ctrl #(.WIDTH(W), .DEPTH(D)) u_ctrl (
    .clk(clk), .rst(rst), .call_req(call_req), .ret_req(ret_req), .irq_req(irq_req),
    .pc_ret(pc_ret), .pc_target(pc_target), .irq_vec(irq_vec), .pc_out(pc_out),
    .pc_load(pc_load), .busy(busy), .stk_read(stk_read), .stk_write(stk_write),
    .stk_data(stk_data), .depth(depth), .full(full), .empty(empty), .err(err)
  );

  avr_cpu_stack #(.WIDTH(W), .DEPTH(D)) u_stack (
    .clk(clk), .rst(rst), .stk_read(stk_read), .stk_write(stk_write), .stk_data(stk_data)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_status(input string tag);
    chk({tag, "_depth"}, 32'(depth), 32'(m_q.size()));
    chk({tag, "_full"},  32'(full),  32'(m_q.size() == D));
    chk({tag, "_empty"}, 32'(empty), 32'(m_q.size() == 0));
    chk({tag, "_err"},   32'(err),   32'(m_err));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    irq_req = 1'b0; ret_req = 1'b0; call_req = 1'b0;
    step();
    step();
    rst = 1'b0;
    m_q.delete();
    m_err = 1'b0;
    m_pc  = '0;
  endtask

  task automatic do_op(input bit irq, input bit ret, input bit call,
                       input logic [W-1:0] pcr, input logic [W-1:0] tgt, input logic [W-1:0] vec);
    bit           is_push, is_pop, bad;
    logic [W-1:0] dest;
    int           guard = 0;
    while (busy && guard < 10) begin
      step();
      guard++;
    end
    if (busy) begin
      chk("idle_wait_timeout", 32'(busy), 32'd0);
      return;
    end
    irq_req = irq; ret_req = ret; call_req = call;
    pc_ret = pcr; pc_target = tgt; irq_vec = vec;
    step();
    irq_req = 1'b0; ret_req = 1'b0; call_req = 1'b0;
    pc_ret = W'($urandom); pc_target = W'($urandom); irq_vec = W'($urandom);

    is_push = irq || (call && !ret);
    is_pop  = !irq && ret;
    if (!is_push && !is_pop) begin
      chk("noop_busy", 32'(busy), 32'd0);
      chk("noop_load", 32'(pc_load), 32'd0);
      chk_status("noop");
      return;
    end
    bad = is_push ? (m_q.size() == D) : (m_q.size() == 0);
    if (bad) begin
      m_err = 1'b1;
      chk("err_busy",  32'(busy),      32'd1);
      chk("err_wr",    32'(stk_write), 32'd0);
      chk("err_rd",    32'(stk_read),  32'd0);
      chk("err_load",  32'(pc_load),   32'd0);
      chk_status("err_c1");
      step();
      chk("err_idle",  32'(busy),    32'd0);
      chk("err_load2", 32'(pc_load), 32'd0);
      chk("err_pc",    32'(pc_out),  32'(m_pc));
      chk_status("err_c2");
      return;
    end
    chk("op_busy", 32'(busy), 32'd1);
    if (is_push) begin
      dest = irq ? vec : tgt;
      chk("push_wr",  32'(stk_write), 32'd1);
      chk("push_rd",  32'(stk_read),  32'd0);
      chk("push_bus", 32'(stk_data),  32'(pcr));
      m_q.push_back(pcr);
    end else begin
      chk("pop_rd",  32'(stk_read),  32'd1);
      chk("pop_wr",  32'(stk_write), 32'd0);
      chk("pop_bus", 32'(stk_data),  32'(m_q[$]));
      dest = m_q.pop_back();
    end
    chk("op_load0", 32'(pc_load), 32'd0);
    step();
    m_pc = dest;
    chk("load_strobe", 32'(pc_load),   32'd1);
    chk("load_pc",     32'(pc_out),    32'(m_pc));
    chk("load_busy",   32'(busy),      32'd1);
    chk("load_wr",     32'(stk_write), 32'd0);
    chk("load_rd",     32'(stk_read),  32'd0);
    chk_status("load");
    step();
    chk("after_busy", 32'(busy),    32'd0);
    chk("after_load", 32'(pc_load), 32'd0);
    chk("after_pc",   32'(pc_out),  32'(m_pc));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

  initial begin
    pc_ret = '0; pc_target = '0; irq_vec = '0;
    do_reset();
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_load",  32'(pc_load),   32'd0);
    chk("rst_pc",    32'(pc_out),    32'd0);
    chk("rst_wr",    32'(stk_write), 32'd0);
    chk("rst_rd",    32'(stk_read),  32'd0);
    chk_status("rst");

    // Single call.
    do_op(0, 0, 1, 9'h010, 9'h100, 9'h000);
    chk("call_pc", 32'(pc_out), 32'h100);

    // Three nested calls then three returns.
    do_reset();
    for (int i = 1; i <= 3; i++) do_op(0, 0, 1, W'(i), W'(9'h40 + i), 9'h0);
    chk("nest_full", 32'(full), 32'd1);
    for (int i = 3; i >= 1; i--) begin
      do_op(0, 1, 0, 9'h0, 9'h0, 9'h0);
      chk("nest_ret_pc", 32'(pc_out), 32'(i));
    end
    chk("nest_empty", 32'(empty), 32'd1);

    // Underflow, then overflow on a fourth call.
    do_op(0, 1, 0, 9'h0, 9'h0, 9'h0);
    chk("uflow_err", 32'(err), 32'd1);
    for (int i = 0; i < 4; i++) do_op(0, 0, 1, W'(9'h20 + i), W'(9'h80 + i), 9'h0);
    chk("oflow_depth", 32'(depth), 32'd3);

    // All three requests at once with one entry stacked: interrupt wins.
    do_op(0, 1, 0, 9'h0, 9'h0, 9'h0);
    do_op(0, 1, 0, 9'h0, 9'h0, 9'h0);
    do_op(1, 1, 1, 9'h055, 9'h0AA, 9'h1F0);
    chk("prio_pc",    32'(pc_out), 32'h1F0);
    chk("prio_depth", 32'(depth),  32'd2);

    // Reset landing in the push cycle.
    call_req = 1'b1; pc_ret = 9'h077; pc_target = 9'h123;
    step();
    call_req = 1'b0;
    chk("mid_wr", 32'(stk_write), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_q.delete(); m_err = 1'b0; m_pc = '0;
    chk("mid_busy", 32'(busy),      32'd0);
    chk("mid_wr0",  32'(stk_write), 32'd0);
    chk("mid_load", 32'(pc_load),   32'd0);
    chk("mid_pc",   32'(pc_out),    32'd0);
    chk_status("mid");
    do_op(0, 1, 0, 9'h0, 9'h0, 9'h0);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      do_op($urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) != 0,
            W'($urandom), W'($urandom), W'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
endmodule
